// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: enqueue side from fetch, dequeue side toward decode, plus flush and occupancy.
// A transfer fires on a side exactly when valid and ready are both high at a rising clk edge; valid never waits on ready.
interface fetch_queue_if #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 12,
   parameter int INSTR_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               flush;
   logic               enq_valid;
   logic [PC_W-1:0]    enq_pc;
   logic [INSTR_W-1:0] enq_instr;
   logic               enq_ready;
   logic               deq_valid;
   logic [PC_W-1:0]    deq_pc;
   logic [INSTR_W-1:0] deq_instr;
   logic               deq_ready;
   logic [CNT_W-1:0]   count;

   modport master (
      output flush, enq_valid, enq_pc, enq_instr, deq_ready,
      input  enq_ready, deq_valid, deq_pc, deq_instr, count
   );

   modport slave (
      input  flush, enq_valid, enq_pc, enq_instr, deq_ready,
      output enq_ready, deq_valid, deq_pc, deq_instr, count
   );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch/decode decoupling FIFO with redirect flush.
// Optional same-cycle forwarding when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 12,
   parameter int INSTR_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_queue_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int ENT_W = PC_W + INSTR_W;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] count;

   logic empty;
   logic full;
   logic enq_fire;
   logic deq_fire;
   logic bypass_take;
   logic do_write;
   logic do_pop;
   logic [ENT_W-1:0] head_entry;

   // Extra wrap bit distinguishes full from empty when indices match.
   assign empty = (head == tail);
   assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
   assign head_entry = mem[head[IDX_W-1:0]];

   assign bus.enq_ready = !full && !bus.flush;
   assign enq_fire      = bus.enq_valid && bus.enq_ready;
   assign deq_fire      = bus.deq_valid && bus.deq_ready;
   assign bus.count     = count;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass_active;
   assign bypass_active = empty && !bus.flush;

   always_comb begin
      bus.deq_valid = 1'b0;
      bus.deq_pc    = '0;
      bus.deq_instr = '0;
      if (bypass_active) begin
         bus.deq_valid = bus.enq_valid;
         if (bus.enq_valid) begin
            bus.deq_pc    = bus.enq_pc;
            bus.deq_instr = bus.enq_instr;
         end
      end else if (!empty && !bus.flush) begin
         bus.deq_valid = 1'b1;
         {bus.deq_pc, bus.deq_instr} = head_entry;
      end
   end

   // A forwarded pair that decode takes immediately never touches storage.
   assign bypass_take = bypass_active && enq_fire && deq_fire;
`else
   always_comb begin
      bus.deq_valid = 1'b0;
      bus.deq_pc    = '0;
      bus.deq_instr = '0;
      if (!empty && !bus.flush) begin
         bus.deq_valid = 1'b1;
         {bus.deq_pc, bus.deq_instr} = head_entry;
      end
   end

   assign bypass_take = 1'b0;
`endif

   assign do_write = enq_fire && !bypass_take;
   assign do_pop   = deq_fire && !bypass_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_write) begin
         mem[tail[IDX_W-1:0]] <= {bus.enq_pc, bus.enq_instr};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (bus.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_write) tail <= tail + PTR_W'(1);
         if (do_pop)   head <= head + PTR_W'(1);
         case ({do_write, do_pop})
            2'b10:   count <= count + PTR_W'(1);
            2'b01:   count <= count - PTR_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/backpressure, drain order, wrap, flush, latency/bypass.
module tb_fetch_queue;
   localparam int DEPTH   = 4;
   localparam int PC_W    = 12;
   localparam int INSTR_W = 32;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   logic [PC_W-1:0] exp_q[$];

   fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_enq(input logic v, input logic [PC_W-1:0] pc);
      bus.enq_valid = v;
      bus.enq_pc    = pc;
      bus.enq_instr = 32'hA000_0000 | 32'(pc);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.deq_ready = 1'b0;
      drive_enq(1'b0, '0);
      repeat (3) tick();

      check("rst_count", 64'(bus.count), 0);
      check("rst_deq_valid", 64'(bus.deq_valid), 0);
      check("rst_deq_pc", 64'(bus.deq_pc), 0);
      check("rst_deq_instr", 64'(bus.deq_instr), 0);
      rst_n = 1'b1;
      tick();
      check("rel_enq_ready", 64'(bus.enq_ready), 1);

      // Fill with decode stalled.
      for (int i = 0; i < 4; i++) begin
         drive_enq(1'b1, PC_W'(4 * i));
         #1;
         check("fill_enq_ready", 64'(bus.enq_ready), 1);
         tick();
      end
      check("fill_count", 64'(bus.count), 4);
      check("fill_full_ready", 64'(bus.enq_ready), 0);
      drive_enq(1'b1, 12'h010);
      tick();
      check("fill_5th_count", 64'(bus.count), 4);
      check("fill_head_stable", 64'(bus.deq_pc), 0);

      // Drain in order.
      drive_enq(1'b0, '0);
      bus.deq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_valid", 64'(bus.deq_valid), 1);
         check("drain_pc", 64'(bus.deq_pc), 64'(4 * i));
         check("drain_instr", 64'(bus.deq_instr), 64'(32'hA000_0000 | (4 * i)));
         tick();
      end
      check("drain_empty_valid", 64'(bus.deq_valid), 0);
      check("drain_count", 64'(bus.count), 0);

      // Prime two entries, then enq+deq every cycle across the index wrap.
      bus.deq_ready = 1'b0;
      drive_enq(1'b1, 12'h100); tick(); exp_q.push_back(12'h100);
      drive_enq(1'b1, 12'h104); tick(); exp_q.push_back(12'h104);
      check("wrap_prime_count", 64'(bus.count), 2);
      bus.deq_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_enq(1'b1, PC_W'(12'h108 + 4 * i));
         #1;
         check("wrap_pc", 64'(bus.deq_pc), 64'(exp_q[0]));
         check("wrap_count", 64'(bus.count), 2);
         tick();
         exp_q.push_back(PC_W'(12'h108 + 4 * i));
         void'(exp_q.pop_front());
      end
      check("wrap_end_count", 64'(bus.count), 2);
      check("wrap_end_head", 64'(bus.deq_pc), 64'(exp_q[0]));

      // Flush with three entries and a pending enqueue.
      bus.deq_ready = 1'b0;
      drive_enq(1'b1, 12'h200);
      tick();
      check("pre_flush_count", 64'(bus.count), 3);
      bus.flush = 1'b1;
      drive_enq(1'b1, 12'h204);
      #1;
      check("flush_enq_ready", 64'(bus.enq_ready), 0);
      check("flush_deq_valid", 64'(bus.deq_valid), 0);
      tick();
      bus.flush = 1'b0;
      drive_enq(1'b0, '0);
      #1;
      check("post_flush_count", 64'(bus.count), 0);
      check("post_flush_valid", 64'(bus.deq_valid), 0);
      check("post_flush_ready", 64'(bus.enq_ready), 1);
      exp_q.delete();

      // Empty queue, enqueue with decode ready: forwarding vs one-cycle latency.
      bus.deq_ready = 1'b1;
      bus.enq_valid = 1'b1;
      bus.enq_pc    = 12'h020;
      bus.enq_instr = 32'h0000_0013;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check("byp_valid", 64'(bus.deq_valid), 1);
      check("byp_pc", 64'(bus.deq_pc), 64'h020);
      check("byp_instr", 64'(bus.deq_instr), 64'h13);
      tick();
      drive_enq(1'b0, '0);
      #1;
      check("byp_count", 64'(bus.count), 0);
      check("byp_after_valid", 64'(bus.deq_valid), 0);
`else
      check("lat_valid_same", 64'(bus.deq_valid), 0);
      tick();
      drive_enq(1'b0, '0);
      #1;
      check("lat_valid_next", 64'(bus.deq_valid), 1);
      check("lat_pc_next", 64'(bus.deq_pc), 64'h020);
      check("lat_instr_next", 64'(bus.deq_instr), 64'h13);
      check("lat_count_next", 64'(bus.count), 1);
      tick();
      check("lat_count_drained", 64'(bus.count), 0);
`endif

      // Asynchronous reset in the middle of traffic.
      bus.deq_ready = 1'b0;
      drive_enq(1'b1, 12'h300); tick();
      drive_enq(1'b1, 12'h304); tick();
      check("pre_rst_count", 64'(bus.count), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_count", 64'(bus.count), 0);
      check("arst_valid", 64'(bus.deq_valid), 0);
      check("arst_pc", 64'(bus.deq_pc), 0);
      check("arst_instr", 64'(bus.deq_instr), 0);
      drive_enq(1'b0, '0);
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_rel_ready", 64'(bus.enq_ready), 1);
      check("arst_rel_count", 64'(bus.count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
